barrier_actuator: RTL and testbench

- Receiving end of the 2-bit TAL barrier command bus.
- Decodes TAL codes (00 DOWN, 01 UP_START, 10 UP, 11 DOWN_START) into a motion target.
- Drives the barrier motor up/down outputs, qualifies the raw limit switches with debouncers, and supervises travel with a timeout.
- Reports position, busy and fault status back to the controller side and to the Basys3 LEDs.

---
 rtl/barrier_pkg.sv | 28 ++
 rtl/limit_debounce.sv | 44 ++++
 rtl/barrier_actuator.sv | 161 ++++++++++++++++
 tb/tb_barrier_actuator.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/barrier_pkg.sv
// Shared definitions for the TAL barrier command bus: actuator state encoding,
// TAL code values and small decode helpers used by actuator, controller and display.
package barrier_pkg;

    typedef enum logic [2:0] {
        INIT    = 3'd0,
        CLOSED  = 3'd1,
        OPENING = 3'd2,
        OPEN    = 3'd3,
        CLOSING = 3'd4,
        FAULT   = 3'd5
    } act_state_t;

    localparam logic [1:0] TAL_DOWN       = 2'b00;
    localparam logic [1:0] TAL_UP_START   = 2'b01;
    localparam logic [1:0] TAL_UP         = 2'b10;
    localparam logic [1:0] TAL_DOWN_START = 2'b11;

    // UP_START and UP both request an open barrier; DOWN and DOWN_START request closed.
    function automatic logic tal_target_up(input logic [1:0] tal);
        return tal[1] ^ tal[0];
    endfunction

    function automatic logic is_moving(input act_state_t s);
        return (s == OPENING) || (s == CLOSING);
    endfunction

endpackage

// File: rtl/limit_debounce.sv
// Limit-switch qualifier: the clean level follows the raw level only after the
// raw input has disagreed with it for DEBOUNCE consecutive clock samples.
module limit_debounce #(
    parameter int DEBOUNCE = 4
) (
    input  logic clk,
    input  logic R,
    input  logic raw,
    output logic clean
);

    localparam int CW = $clog2(DEBOUNCE + 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;
    logic          clean_q;
    logic          clean_d;

    // A single agreeing sample restarts the qualification window.
    always_comb begin
        cnt_d   = '0;
        clean_d = clean_q;
        if (raw != clean_q) begin
            if (cnt_q == CW'(DEBOUNCE - 1)) begin
                clean_d = raw;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            cnt_q   <= '0;
            clean_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            clean_q <= clean_d;
        end
    end

    assign clean = clean_q;

endmodule

// File: rtl/barrier_actuator.sv
// Barrier actuator: decodes the TAL command into a motion target, drives the motor,
// qualifies the limit switches and supervises travel time, reporting status back.
module barrier_actuator
    import barrier_pkg::*;
#(
    parameter int DEBOUNCE       = 4,
    parameter int TIMEOUT_CYCLES = 32
) (
    input  logic       clk,
    input  logic       R,
    input  logic [1:0] TAL,
    input  logic       lim_up,
    input  logic       lim_down,
    output logic       motor_up,
    output logic       motor_down,
    output logic       at_up,
    output logic       at_down,
    output logic       busy,
    output logic       fault,
    output logic [2:0] state_o
);

    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0] lim_raw;
    logic [1:0] lim_clean;
    logic       lim_up_clean;
    logic       lim_down_clean;

    // Index 1 is the upper switch, index 0 the lower switch.
    assign lim_raw = {lim_up, lim_down};

    for (genvar gi = 0; gi < 2; gi++) begin : g_deb
        limit_debounce #(
            .DEBOUNCE(DEBOUNCE)
        ) u_deb (
            .clk  (clk),
            .R    (R),
            .raw  (lim_raw[gi]),
            .clean(lim_clean[gi])
        );
    end

    assign lim_up_clean   = lim_clean[1];
    assign lim_down_clean = lim_clean[0];

    act_state_t    state_q;
    act_state_t    state_d;
    logic [TW-1:0] timer_q;
    logic [TW-1:0] timer_d;
    logic          motor_up_q;
    logic          motor_up_d;
    logic          motor_down_q;
    logic          motor_down_d;
    logic          at_up_q;
    logic          at_up_d;
    logic          at_down_q;
    logic          at_down_d;
    logic          busy_q;
    logic          busy_d;
    logic          fault_q;
    logic          fault_d;

    logic target_up;
    logic conflict;
    logic timeout;

    assign target_up = tal_target_up(TAL);
    assign conflict  = lim_up_clean & lim_down_clean;
    assign timeout   = (timer_q == '0);

    always_comb begin
        state_d = state_q;
        case (state_q)
            INIT: begin
                state_d = lim_down_clean ? CLOSED : CLOSING;
            end
            CLOSED: begin
                if (conflict)       state_d = FAULT;
                else if (target_up) state_d = OPENING;
            end
            OPENING: begin
                if (conflict)          state_d = FAULT;
                else if (lim_up_clean) state_d = OPEN;
                else if (!target_up)   state_d = CLOSING;
                else if (timeout)      state_d = FAULT;
            end
            OPEN: begin
                if (conflict)        state_d = FAULT;
                else if (!target_up) state_d = CLOSING;
            end
            CLOSING: begin
                if (conflict)            state_d = FAULT;
                else if (lim_down_clean) state_d = CLOSED;
                else if (target_up)      state_d = OPENING;
                else if (timeout)        state_d = FAULT;
            end
            FAULT: begin
                // Recovery only once the barrier is verifiably down and asked to stay down.
                if (!target_up && lim_down_clean && !lim_up_clean) state_d = CLOSED;
            end
            default: begin
                state_d = INIT;
            end
        endcase
    end

    // Every entry into a travel state, reversals included, restarts the travel budget.
    always_comb begin
        timer_d = '0;
        if (is_moving(state_d)) begin
            if (state_d != state_q) begin
                timer_d = TW'(TIMEOUT_CYCLES);
            end else begin
                timer_d = timer_q - 1'b1;
            end
        end
    end

    // Outputs are decoded from the next state and registered, so they always
    // match a Moore decode of state_q while staying glitch-free at the pins.
    always_comb begin
        motor_up_d   = (state_d == OPENING);
        motor_down_d = (state_d == CLOSING);
        at_up_d      = (state_d == OPEN);
        at_down_d    = (state_d == CLOSED);
        busy_d       = (state_d == INIT) || (state_d == OPENING) || (state_d == CLOSING);
        fault_d      = (state_d == FAULT);
    end

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            state_q      <= INIT;
            timer_q      <= '0;
            motor_up_q   <= 1'b0;
            motor_down_q <= 1'b0;
            at_up_q      <= 1'b0;
            at_down_q    <= 1'b0;
            busy_q       <= 1'b1;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            timer_q      <= timer_d;
            motor_up_q   <= motor_up_d;
            motor_down_q <= motor_down_d;
            at_up_q      <= at_up_d;
            at_down_q    <= at_down_d;
            busy_q       <= busy_d;
            fault_q      <= fault_d;
        end
    end

    assign motor_up   = motor_up_q;
    assign motor_down = motor_down_q;
    assign at_up      = at_up_q;
    assign at_down    = at_down_q;
    assign busy       = busy_q;
    assign fault      = fault_q;
    assign state_o    = state_q;

endmodule

// File: tb/tb_barrier_actuator.sv
// Randomized bench for barrier_actuator: a behavioural model predicts the outputs after
// every clock edge into a queue, and a monitor pops and compares them mid-cycle.
module tb_barrier_actuator;
    import barrier_pkg::*;

    localparam int DEB = 4;
    localparam int TMO = 32;

    logic       clk = 1'b0;
    logic       R = 1'b0;
    logic [1:0] TAL = TAL_DOWN;
    logic       lim_up = 1'b0;
    logic       lim_down = 1'b1;
    logic       motor_up;
    logic       motor_down;
    logic       at_up;
    logic       at_down;
    logic       busy;
    logic       fault;
    logic [2:0] state_o;

    barrier_actuator #(
        .DEBOUNCE      (DEB),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk       (clk),
        .R         (R),
        .TAL       (TAL),
        .lim_up    (lim_up),
        .lim_down  (lim_down),
        .motor_up  (motor_up),
        .motor_down(motor_down),
        .at_up     (at_up),
        .at_down   (at_down),
        .busy      (busy),
        .fault     (fault),
        .state_o   (state_o)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       mu;
        logic       md;
        logic       au;
        logic       ad;
        logic       bz;
        logic       ft;
        logic [2:0] st;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   failures = 0;

    // Reference model: barrier "modes" with elapsed travel time and switch histories.
    typedef enum int {M_HOME, M_SHUT, M_RAISE, M_RAISED, M_LOWER, M_ERR} mode_t;

    function automatic exp_t expect_of(input mode_t m);
        exp_t e;
        e = '0;
        case (m)
            M_HOME:   begin e.bz = 1'b1; e.st = INIT;    end
            M_SHUT:   begin e.ad = 1'b1; e.st = CLOSED;  end
            M_RAISE:  begin e.mu = 1'b1; e.bz = 1'b1; e.st = OPENING; end
            M_RAISED: begin e.au = 1'b1; e.st = OPEN;    end
            M_LOWER:  begin e.md = 1'b1; e.bz = 1'b1; e.st = CLOSING; end
            default:  begin e.ft = 1'b1; e.st = FAULT;   end
        endcase
        return e;
    endfunction

    initial begin : model_proc
        mode_t m_mode;
        mode_t nxt;
        int    m_elapsed;
        bit    up_c;
        bit    dn_c;
        bit    want_up;
        bit    all_diff;
        bit    up_hist[$];
        bit    dn_hist[$];
        m_mode = M_HOME;
        m_elapsed = 0;
        up_c = 1'b0;
        dn_c = 1'b0;
        forever begin
            @(posedge clk);
            if (!R) begin
                m_mode = M_HOME;
                m_elapsed = 0;
                up_c = 1'b0;
                dn_c = 1'b0;
                up_hist.delete();
                dn_hist.delete();
            end else begin
                want_up = (TAL == TAL_UP_START) || (TAL == TAL_UP);
                nxt = m_mode;
                if (m_mode == M_HOME) begin
                    nxt = dn_c ? M_SHUT : M_LOWER;
                end else if (m_mode == M_ERR) begin
                    if (!want_up && dn_c && !up_c) nxt = M_SHUT;
                end else if (up_c && dn_c) begin
                    nxt = M_ERR;
                end else begin
                    case (m_mode)
                        M_SHUT:   if (want_up) nxt = M_RAISE;
                        M_RAISED: if (!want_up) nxt = M_LOWER;
                        M_RAISE: begin
                            if (up_c) nxt = M_RAISED;
                            else if (!want_up) nxt = M_LOWER;
                            else if (m_elapsed >= TMO) nxt = M_ERR;
                        end
                        M_LOWER: begin
                            if (dn_c) nxt = M_SHUT;
                            else if (want_up) nxt = M_RAISE;
                            else if (m_elapsed >= TMO) nxt = M_ERR;
                        end
                        default: nxt = m_mode;
                    endcase
                end
                if (nxt != m_mode) m_elapsed = 0;
                else m_elapsed = m_elapsed + 1;
                m_mode = nxt;
                // A switch level is accepted once the last DEB samples all disagree with it.
                up_hist.push_back(lim_up);
                if (up_hist.size() > DEB) void'(up_hist.pop_front());
                dn_hist.push_back(lim_down);
                if (dn_hist.size() > DEB) void'(dn_hist.pop_front());
                all_diff = (up_hist.size() == DEB);
                foreach (up_hist[i]) if (up_hist[i] == up_c) all_diff = 1'b0;
                if (all_diff) up_c = !up_c;
                all_diff = (dn_hist.size() == DEB);
                foreach (dn_hist[i]) if (dn_hist[i] == dn_c) all_diff = 1'b0;
                if (all_diff) dn_c = !dn_c;
            end
            exp_q.push_back(expect_of(m_mode));
        end
    end

    initial begin : monitor_proc
        exp_t e;
        exp_t got;
        forever begin
            @(negedge clk);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                got = '{motor_up, motor_down, at_up, at_down, busy, fault, state_o};
                checks++;
                if (got !== e) begin
                    failures++;
                    $display("FAIL outputs t=%0t got mu=%b md=%b au=%b ad=%b busy=%b fault=%b st=%0d want mu=%b md=%b au=%b ad=%b busy=%b fault=%b st=%0d",
                             $time, got.mu, got.md, got.au, got.ad, got.bz, got.ft, got.st,
                             e.mu, e.md, e.au, e.ad, e.bz, e.ft, e.st);
                end
                checks++;
                if (motor_up && motor_down) begin
                    failures++;
                    $display("FAIL motor_exclusive t=%0t got mu=%b md=%b want not both", $time, motor_up, motor_down);
                end
            end
        end
    end

    task automatic drive(input logic [1:0] tal, input logic lu, input logic ld, input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            #1;
            TAL = tal;
            lim_up = lu;
            lim_down = ld;
        end
    endtask

    task automatic pulse_reset(input int n);
        @(negedge clk);
        #1;
        R = 1'b0;
        #1;
        checks++;
        if (motor_up || motor_down || !busy || state_o != INIT) begin
            failures++;
            $display("FAIL async_reset t=%0t got mu=%b md=%b busy=%b st=%0d want mu=0 md=0 busy=1 st=%0d",
                     $time, motor_up, motor_down, busy, state_o, INIT);
        end
        drive(TAL, lim_up, lim_down, n);
        @(negedge clk);
        #1;
        R = 1'b1;
    endtask

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog t=%0t got no finish want finish", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        logic [1:0] open_code;
        logic [1:0] rt;
        drive(TAL_DOWN, 1'b0, 1'b1, 3);
        @(negedge clk);
        #1;
        R = 1'b1;
        drive(TAL_DOWN, 1'b0, 1'b1, 8);
        $display("scenario homing t=%0t checks=%0d", $time, checks);

        open_code = ($urandom_range(0, 1) == 0) ? TAL_UP_START : TAL_UP;
        drive(open_code, 1'b0, 1'b1, 2);
        drive(open_code, 1'b1, 1'b0, 8);
        drive(TAL_UP, 1'b1, 1'b0, 3);
        drive(TAL_UP_START, 1'b1, 1'b0, 3);
        $display("scenario open t=%0t checks=%0d", $time, checks);

        drive(TAL_DOWN_START, 1'b1, 1'b0, 2);
        drive(TAL_DOWN_START, 1'b0, 1'b1, 8);
        drive(TAL_DOWN, 1'b0, 1'b1, 2);
        $display("scenario close t=%0t checks=%0d", $time, checks);

        drive(TAL_UP_START, 1'b0, 1'b1, 2);
        drive(TAL_UP_START, 1'b1, 1'b0, 8);
        drive(TAL_DOWN_START, 1'b1, 1'b0, 2);
        drive(TAL_DOWN_START, 1'b0, 1'b0, 10);
        drive(TAL_UP_START, 1'b0, 1'b0, 40);
        $display("scenario reversal_reload t=%0t checks=%0d", $time, checks);
        drive(TAL_DOWN, 1'b0, 1'b1, 8);

        drive(TAL_UP_START, 1'b0, 1'b0, 40);
        drive(TAL_DOWN, 1'b0, 1'b1, 8);
        $display("scenario timeout t=%0t checks=%0d", $time, checks);

        drive(TAL_DOWN, 1'b1, 1'b1, 8);
        drive(TAL_DOWN, 1'b0, 1'b1, 8);
        $display("scenario conflict t=%0t checks=%0d", $time, checks);

        drive(TAL_UP, 1'b0, 1'b1, 2);
        drive(TAL_UP, 1'b1, 1'b0, 3);
        drive(TAL_UP, 1'b0, 1'b0, 3);
        drive(TAL_UP, 1'b1, 1'b0, 6);
        $display("scenario glitch t=%0t checks=%0d", $time, checks);

        drive(TAL_DOWN_START, 1'b1, 1'b0, 3);
        pulse_reset(2);
        drive(TAL_DOWN, 1'b0, 1'b0, 3);
        drive(TAL_DOWN, 1'b0, 1'b1, 8);
        $display("scenario midmotion_reset t=%0t checks=%0d", $time, checks);

        for (int b = 0; b < 90; b++) begin
            rt = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 39) == 0) begin
                pulse_reset($urandom_range(1, 3));
            end else begin
                drive(rt, 1'($urandom_range(0, 2) == 0), 1'($urandom_range(0, 1)),
                      $urandom_range(1, 14));
            end
        end
        $display("scenario random t=%0t checks=%0d", $time, checks);

        drive(TAL_DOWN, 1'b0, 1'b1, 2);
        @(negedge clk);
        @(negedge clk);
        #2;
        checks++;
        if (exp_q.size() > 1) begin
            failures++;
            $display("FAIL queue_drain got %0d pending want at most 1", exp_q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
